hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline scheduler for the 5-stage LEGv8 datapath (IF/ID/EX/MEM/WB).
- Generates per-stage stall (hold) and flush (bubble) controls for the pipeline registers and PC, covering:
  - load-use hazards;
  - taken branches resolved in MEM;
  - multi-cycle data-memory accesses via a dm_ready handshake.
- Sits beside the datapath and is driven by register fields and control bits already carried in the pipeline registers.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- REG_W, 5: register-address width.
- PERF_W, 32: stall/flush counter width.
- WAIT_MAX, 15: maximum MEM_WAIT cycles before timeout (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rn_D  in  REG_W  first source register of the instruction in ID.
- rm_D  in  REG_W  second source register (post reg2loc select) in ID.
- uses_rm_D  in  1  ID instruction reads rm_D.
- rd_E  in  REG_W  destination register of the instruction in EX.
- memRead_E  in  1  EX instruction is a load.
- PCSrc_M  in  1  taken branch in MEM.
- dm_req_M  in  1  MEM instruction accesses data memory (read or write).
- dm_ready  in  1  data memory completes the access this cycle.
- stall_F  out  1  hold PC.
- stall_D  out  1  hold IF_ID.
- stall_E  out  1  hold ID_EX.
- stall_M  out  1  hold EX_MEM.
- flush_D  out  1  clear IF_ID.
- flush_E  out  1  clear ID_EX.
- flush_M  out  1  clear EX_MEM.
- flush_W  out  1  clear MEM_WB (bubble into WB).
- dm_timeout  out  1  sticky; memory wait exceeded WAIT_MAX.
- stall_cnt  out  PERF_W  cycles with stall_F=1.
- flush_cnt  out  PERF_W  taken-branch flush events.

Behaviour:
- States: RUN, MEM_WAIT, ERR. A wait counter of 8 bits is sufficient for WAIT_MAX ≤ 255.
- Control outputs are combinational (Mealy) from the current state and inputs, with no added latency. State and counters are registered.
- Reset low (asynchronous):
  - state goes to RUN; wait counter, stall_cnt, flush_cnt and dm_timeout go to 0;
  - all stall/flush outputs are forced to 0 while reset is low.
- Priority: ERR > MEM_WAIT/memory stall > branch flush > load-use.
- Load-use hazard (RUN only):
  - Condition: memRead_E && rd_E!=31 && (rd_E==rn_D || (uses_rm_D && rd_E==rm_D)).
  - Response: stall_F=stall_D=flush_E=1 for that cycle. The condition clears on the next cycle because EX then holds a bubble.
  - X31 (XZR) never produces a hazard.
- Taken branch (RUN, PCSrc_M=1, no memory stall):
  - flush_D=flush_E=flush_M=1 in the same cycle.
  - Load-use is suppressed and stall_F=0 so the PC loads the branch target.
  - flush_cnt increments by 1.
- Memory stall:
  - RUN with dm_req_M && !dm_ready:
    - stall_F=stall_D=stall_E=stall_M=1 and flush_W=1;
    - next state MEM_WAIT, wait counter = 1.
  - MEM_WAIT:
    - dm_ready=0 drives the same outputs and increments the wait counter.
    - dm_ready=1 releases all stalls in that cycle, drives flush_W=0, returns to RUN and clears the counter.
    - On release, the branch and load-use rules are evaluated normally in the same cycle.
  - Access with dm_ready=1 in the request cycle: zero stall cycles.
  - PCSrc_M asserted during a memory stall: the flush is deferred until release and counted once.
- Timeout: in MEM_WAIT, if dm_ready=0 and the wait counter == WAIT_MAX:
  - next state ERR; dm_timeout set to 1.
  - ERR holds all four stalls and flush_W at 1 until reset, ignoring all inputs.
- Counters:
  - stall_cnt +1 every cycle with stall_F=1, including ERR.
  - Both counters saturate at all-ones and never wrap.
- Reset asserted mid-wait: state aborts to RUN immediately and outputs drop to 0 asynchronously.

Decomposition:
- Package hazard_pkg holds:
  - typedef enum state_t {RUN, MEM_WAIT, ERR};
  - localparam XZR = 5'd31;
  - default widths.
- One sub-module: sat_counter #(W) with clk, reset, inc and q. It is instantiated for stall_cnt and flush_cnt.

Test Plan:
- Load-use: memRead_E=1, rd_E=3, rn_D=3 for 1 cycle -> stall_F=stall_D=flush_E=1 that cycle only; stall_cnt=1. Repeating with rd_E=31 -> no stall.
- uses_rm_D gating: rd_E=7, rm_D=7, uses_rm_D=0 then 1 -> no stall, then stall.
- Branch + load-use same cycle: PCSrc_M=1 with the load-use condition true -> flush_D/E/M=1, stall_F=0; flush_cnt=1.
- Memory wait: dm_req_M=1, dm_ready=0 for 3 cycles, then 1 -> all stalls and flush_W=1 for 3 cycles, released in the 4th; stall_cnt=3; state back to RUN.
- Timeout: WAIT_MAX=4, dm_ready held 0 -> ERR after the 5th stall cycle; dm_timeout=1 persists with dm_ready=1 until reset goes low.
- Reset mid-MEM_WAIT: reset low asynchronously -> all outputs 0 before the next clk edge; counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared types and defaults for the LEGv8 hazard controller.
//   state_t   - scheduler FSM states
//   XZR       - zero register index, never a hazard source
//   DEF_*     - default parameter values
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] XZR = 5'd31;

    localparam int DEF_REG_W    = 5;
    localparam int DEF_PERF_W   = 32;
    localparam int DEF_WAIT_MAX = 15;
    localparam int WAIT_CNT_W   = 8;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   - clock
//   reset - asynchronous active-low reset, clears q
//   inc   - count enable for this cycle
//   q     - current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler for the 5-stage LEGv8 pipeline.
//   Inputs : rn_D/rm_D/uses_rm_D (ID sources), rd_E/memRead_E (EX load),
//            PCSrc_M (taken branch in MEM), dm_req_M/dm_ready (data memory
//            handshake), clk, reset (async active-low).
//   Outputs: stall_F/D/E/M (hold PC and pipeline regs), flush_D/E/M/W
//            (bubble pipeline regs), dm_timeout (sticky), stall_cnt and
//            flush_cnt (saturating performance counters).
// Controls are Mealy outputs of the registered state; nothing adds latency.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = DEF_REG_W,
    parameter int PERF_W   = DEF_PERF_W,
    parameter int WAIT_MAX = DEF_WAIT_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  rn_D,
    input  logic [REG_W-1:0]  rm_D,
    input  logic              uses_rm_D,
    input  logic [REG_W-1:0]  rd_E,
    input  logic              memRead_E,
    input  logic              PCSrc_M,
    input  logic              dm_req_M,
    input  logic              dm_ready,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              stall_M,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic              flush_W,
    output logic              dm_timeout,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(WAIT_MAX);

    state_t                state, state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_nxt;

    logic lu_cond, mem_stall, run_eval, branch, load_use, hold_all;

    // XZR reads as zero, so a load targeting it can never feed a consumer.
    assign lu_cond = memRead_E && (rd_E != REG_W'(XZR)) &&
                     ((rd_E == rn_D) || (uses_rm_D && (rd_E == rm_D)));

    assign mem_stall = ((state == RUN) && dm_req_M && !dm_ready) ||
                       ((state == MEM_WAIT) && !dm_ready);

    // Cycles in which the pipeline advances: normal RUN, or the release
    // cycle of a wait, where a deferred branch / load-use is handled at once.
    assign run_eval = ((state == RUN) && !(dm_req_M && !dm_ready)) ||
                      ((state == MEM_WAIT) && dm_ready);

    assign branch   = reset && run_eval && PCSrc_M;
    assign load_use = reset && run_eval && !PCSrc_M && lu_cond;
    assign hold_all = reset && ((state == ERR) || mem_stall);

    assign stall_F = hold_all || load_use;
    assign stall_D = hold_all || load_use;
    assign stall_E = hold_all;
    assign stall_M = hold_all;
    assign flush_D = branch;
    assign flush_E = branch || load_use;
    assign flush_M = branch;
    // The stalled MEM instruction must not also retire into WB each cycle.
    assign flush_W = hold_all;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (dm_req_M && !dm_ready) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dm_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LIM) begin
                    state_nxt = ERR;
                end else begin
                    wait_nxt  = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            dm_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if ((state == MEM_WAIT) && !dm_ready && (wait_cnt == WAIT_LIM))
                dm_timeout <= 1'b1;
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_F),
        .q     (stall_cnt)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Inputs change just after the falling edge;
// outputs are sampled 1ns later, well away from the rising edge. A second
// instance with 3-bit counters shares the stimulus to exercise saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rn_D, rm_D, rd_E;
    logic       uses_rm_D, memRead_E, PCSrc_M, dm_req_M, dm_ready;

    logic        stall_F, stall_D, stall_E, stall_M;
    logic        flush_D, flush_E, flush_M, flush_W, dm_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_F2, s_D2, s_E2, s_M2, f_D2, f_E2, f_M2, f_W2, tmo2;
    logic [2:0]  stall_cnt2, flush_cnt2;

    logic [7:0]  ctl;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W}
    assign ctl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W};

    hazard_ctrl #(.REG_W(5), .PERF_W(32), .WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .rn_D(rn_D), .rm_D(rm_D), .uses_rm_D(uses_rm_D),
        .rd_E(rd_E), .memRead_E(memRead_E), .PCSrc_M(PCSrc_M), .dm_req_M(dm_req_M),
        .dm_ready(dm_ready), .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .stall_M(stall_M), .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
        .flush_W(flush_W), .dm_timeout(dm_timeout), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.REG_W(5), .PERF_W(3), .WAIT_MAX(4)) dut_sat (
        .clk(clk), .reset(reset), .rn_D(rn_D), .rm_D(rm_D), .uses_rm_D(uses_rm_D),
        .rd_E(rd_E), .memRead_E(memRead_E), .PCSrc_M(PCSrc_M), .dm_req_M(dm_req_M),
        .dm_ready(dm_ready), .stall_F(s_F2), .stall_D(s_D2), .stall_E(s_E2),
        .stall_M(s_M2), .flush_D(f_D2), .flush_E(f_E2), .flush_M(f_M2),
        .flush_W(f_W2), .dm_timeout(tmo2), .stall_cnt(stall_cnt2),
        .flush_cnt(flush_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge (one full clock consumed).
    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rn_D = 5'd0; rm_D = 5'd0; rd_E = 5'd0; uses_rm_D = 1'b0;
        memRead_E = 1'b0; PCSrc_M = 1'b0; dm_req_M = 1'b0; dm_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        #1;
        check("reset_ctl",      32'(ctl),        32'h00);
        check("reset_stallcnt", stall_cnt,       32'd0);
        check("reset_flushcnt", flush_cnt,       32'd0);
        check("reset_timeout",  32'(dm_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("idle_ctl", 32'(ctl), 32'h00);

        // Load-use on rn: stall_F, stall_D, flush_E for one cycle.
        memRead_E = 1'b1; rd_E = 5'd3; rn_D = 5'd3;
        #1 check("lu_rn_ctl", 32'(ctl), 32'b1100_0100);
        next_cyc();
        idle_inputs();
        #1 check("lu_rn_clear", 32'(ctl), 32'h00);
        check("lu_rn_stallcnt", stall_cnt, 32'd1);

        // Load to XZR never stalls.
        memRead_E = 1'b1; rd_E = 5'd31; rn_D = 5'd31;
        #1 check("lu_xzr_ctl", 32'(ctl), 32'h00);
        next_cyc();

        // rm match only counts when uses_rm_D is set.
        memRead_E = 1'b1; rd_E = 5'd7; rn_D = 5'd1; rm_D = 5'd7; uses_rm_D = 1'b0;
        #1 check("lu_rm_unused", 32'(ctl), 32'h00);
        uses_rm_D = 1'b1;
        #1 check("lu_rm_used", 32'(ctl), 32'b1100_0100);
        next_cyc();
        check("lu_rm_stallcnt", stall_cnt, 32'd2);

        // Branch beats load-use: flush D/E/M, PC not held.
        PCSrc_M = 1'b1;
        #1 check("br_lu_ctl", 32'(ctl), 32'b0000_1110);
        next_cyc();
        idle_inputs();
        #1 check("br_flushcnt", flush_cnt, 32'd1);
        check("br_stallcnt", stall_cnt, 32'd2);

        // Memory wait 3 cycles with a pending branch that must be deferred.
        dm_req_M = 1'b1; dm_ready = 1'b0; PCSrc_M = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("mw_hold%0d", i), 32'(ctl), 32'b1111_0001);
            next_cyc();
        end
        check("mw_nobranchcnt", flush_cnt, 32'd1);
        dm_ready = 1'b1;
        #1 check("mw_release", 32'(ctl), 32'b0000_1110);
        next_cyc();
        idle_inputs();
        #1 check("mw_stallcnt", stall_cnt, 32'd5);
        check("mw_flushcnt", flush_cnt, 32'd2);
        check("mw_back_run", 32'(ctl), 32'h00);

        // Access satisfied in the request cycle costs nothing.
        dm_req_M = 1'b1; dm_ready = 1'b1;
        #1 check("mem_zero_wait", 32'(ctl), 32'h00);
        next_cyc();
        idle_inputs();
        #1 check("zw_stallcnt", stall_cnt, 32'd5);

        // Timeout with WAIT_MAX=4: ERR after 5 stall cycles.
        dm_req_M = 1'b1; dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) next_cyc();
        check("tmo_not_yet", 32'(dm_timeout), 32'd0);
        next_cyc();
        check("tmo_set", 32'(dm_timeout), 32'd1);
        check("tmo_stallcnt", stall_cnt, 32'd10);
        // ERR ignores ready, branch and load-use inputs.
        dm_ready = 1'b1; dm_req_M = 1'b0; PCSrc_M = 1'b1;
        memRead_E = 1'b1; rd_E = 5'd2; rn_D = 5'd2;
        #1 check("err_ctl", 32'(ctl), 32'b1111_0001);
        for (int i = 0; i < 3; i++) next_cyc();
        check("err_ctl_hold", 32'(ctl), 32'b1111_0001);
        check("err_timeout_sticky", 32'(dm_timeout), 32'd1);
        check("err_stallcnt", stall_cnt, 32'd13);
        check("sat_stallcnt", 32'(stall_cnt2), 32'd7);
        check("sat_flushcnt", 32'(flush_cnt2), 32'd2);

        // Asynchronous reset from ERR mid-cycle.
        #2 reset = 1'b0;
        #1 check("rst_err_ctl", 32'(ctl), 32'h00);
        check("rst_err_timeout", 32'(dm_timeout), 32'd0);
        check("rst_err_stallcnt", stall_cnt, 32'd0);
        idle_inputs();
        next_cyc();
        reset = 1'b1;

        // Enter MEM_WAIT, then pull reset mid-cycle.
        dm_req_M = 1'b1; dm_ready = 1'b0;
        next_cyc();
        #1 check("mw2_hold", 32'(ctl), 32'b1111_0001);
        #1 reset = 1'b0;
        #1 check("rst_mw_ctl", 32'(ctl), 32'h00);
        check("rst_mw_stallcnt", stall_cnt, 32'd0);
        check("rst_mw_flushcnt", flush_cnt, 32'd0);
        next_cyc();
        // Back in RUN: ready low with no request must not stall.
        reset = 1'b1; dm_req_M = 1'b0; dm_ready = 1'b0;
        #1 check("rst_mw_run", 32'(ctl), 32'h00);
        next_cyc();
        check("rst_mw_run_cnt", stall_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
